// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the line-granular UART arbiter.
// Optional idle-timeout release is built with UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] CHAR_LF = 8'h0a;
  localparam logic [7:0] CHAR_CR = 8'h0d;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CHAR_LF) || (b == CHAR_CR);
  endfunction

endpackage

// File: rtl/uart_line_arbiter_rr_pick.sv
// Round-robin first-valid finder: scans req from last+1, wrapping.
// Purely combinational; any is low when no request is pending.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk offsets from far to near so the nearest hit is written last
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      sum = {1'b0, last} + (IW+1)'(i);
      if (sum >= (IW+1)'(N))
        idx = IW'(sum - (IW+1)'(N));
      else
        idx = IW'(sum);
      if (req[idx]) begin
        any       = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/uart_line_arbiter.sv
// Shares one UART byte sink between NREQ sources, one whole line per grant.
// Define UART_ARB_TIMEOUT_EN to release a stalled lock after TIMEOUT idle cycles.
module uart_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ*8-1:0]        req_data,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NREQ)-1:0]  out_src,
  output logic                     out_eol,
  output logic [$clog2(NREQ)-1:0]  lock_owner,
  output logic                     locked,
  output logic                     timeout_evt
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_cfg_err
    $error("uart_line_arbiter: unsupported NREQ or TIMEOUT");
  end

  arb_state_e    state, state_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] owner_nxt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [7:0]    own_byte;
  logic          own_valid;
  logic          slot_free;
  logic          xfer;
  logic          expire;

  rr_pick #(.N(NREQ)) u_pick (
    .req       (req_valid),
    .last      (last),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign own_byte  = req_data[{lock_owner, 3'b000} +: 8];
  assign own_valid = req_valid[lock_owner];
  assign slot_free = !out_valid || out_ready;
  assign xfer      = (state == LOCKED) && own_valid && slot_free;
  assign locked    = (state == LOCKED);

  always_comb begin
    req_ready = '0;
    if (state == LOCKED)
      req_ready[lock_owner] = slot_free;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;

  // A transfer on the threshold cycle keeps the lock
  assign expire = (state == LOCKED) && !xfer &&
                  (idle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= expire;
      if (state != LOCKED || xfer || expire)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = lock_owner;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = LOCKED;
          owner_nxt = pick_idx;
        end
      end
      LOCKED: begin
        if ((xfer && is_eol(own_byte)) || expire) begin
          state_nxt = IDLE;
          last_nxt  = lock_owner;
        end
      end
      default: ;
    endcase
  end

  // last starts at NREQ-1 so source 0 wins the first arbitration
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last       <= IW'(NREQ - 1);
      lock_owner <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      lock_owner <= owner_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_eol   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= own_byte;
      out_src   <= lock_owner;
      out_eol   <= is_eol(own_byte);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter with a scoreboard of expected bytes.
// Expectations follow the UART_ARB_TIMEOUT_EN setting of the build.
module tb_uart_line_arbiter;

  localparam int NREQ = 3;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_src;
  logic              out_eol;
  logic [1:0]        lock_owner;
  logic              locked;
  logic              timeout_evt;

  logic [7:0] src_q [NREQ][$];
  exp_t       exp_q [$];

  int nchk = 0;
  int nfail = 0;
  int gaps = 0;
  int tevt_cnt = 0;
  bit seen_out = 0;

  uart_line_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_src     (out_src),
    .out_eol     (out_eol),
    .lock_owner  (lock_owner),
    .locked      (locked),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input string str);
    for (int i = 0; i < str.len(); i++)
      src_q[s].push_back(str[i]);
  endtask

  task automatic expect_line(input int s, input string str);
    exp_t e;
    for (int i = 0; i < str.len(); i++) begin
      e.src  = 2'(s);
      e.data = str[i];
      exp_q.push_back(e);
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < NREQ; i++)
      if (src_q[i].size() > 0) p = 1;
    return p;
  endfunction

  // Called at a falling edge; returns at the next falling edge
  task automatic step();
    logic [NREQ-1:0] fire;
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = src_q[i].size() > 0;
      req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    #1;
    fire = req_valid & req_ready;
    if (out_valid && !out_ready)
      chk("stall_ready", 32'(req_ready), 0);
    if (timeout_evt) tevt_cnt++;
    if (out_valid) seen_out = 1;
    else if (seen_out && exp_q.size() > 0) gaps++;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_src", 32'(out_src), 32'(e.src));
        chk("out_eol", 32'(out_eol),
            32'(e.data == 8'h0a || e.data == 8'h0d));
      end
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (fire[i]) src_q[i].delete(0);
  endtask

  task automatic drain(input int maxc, input bit toggle);
    int n = 0;
    while ((exp_q.size() > 0 || pending() || out_valid) && n < maxc) begin
      if (toggle) out_ready = (n % 3 == 0);
      step();
      n++;
    end
    out_ready = 1'b1;
    chk("drain_bound", 32'(n < maxc), 1);
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    seen_out = 0;
    gaps = 0;
    tevt_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_out_eol", 32'(out_eol), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_owner", 32'(lock_owner), 0);
    chk("rst_tevt", 32'(timeout_evt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    resetn = 1'b1;

    // single source, latency and terminator
    send(0, "hi\n");
    expect_line(0, "hi\n");
    step();
    chk("t1_locked", 32'(locked), 1);
    chk("t1_owner", 32'(lock_owner), 0);
    chk("t1_lat_n1", 32'(out_valid), 0);
    step();
    chk("t1_lat_n2", 32'(out_valid), 1);
    step();
    step();
    chk("t1_unlock", 32'(locked), 0);
    chk("t1_lf_data", 32'(out_data), 32'h0a);
    drain(20, 0);
    chk("t1_gaps", 32'(gaps), 0);

    // two sources in the same cycle
    reset_dut();
    send(0, "ab\n");
    send(1, "ab\n");
    expect_line(0, "ab\n");
    expect_line(1, "ab\n");
    drain(40, 0);
    chk("t2_gaps", 32'(gaps), 1);

    // round-robin fairness
    reset_dut();
    for (int s = 0; s < NREQ; s++) send(s, "x\nx\n");
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NREQ; s++) expect_line(s, "x\n");
    drain(60, 0);
    chk("t3_gaps", 32'(gaps), 5);

    // backpressure
    reset_dut();
    send(1, "abc\n");
    expect_line(1, "abc\n");
    drain(60, 1);

    // stalled lock
    reset_dut();
    send(2, "ab");
    expect_line(2, "ab");
    step();
    chk("t5_owner", 32'(lock_owner), 2);
    send(0, "z\n");
`ifdef UART_ARB_TIMEOUT_EN
    expect_line(0, "z\n");
    drain(80, 0);
    chk("t5_tevt_cnt", 32'(tevt_cnt), 1);
`else
    repeat (20) step();
    chk("t5_held", 32'(locked), 1);
    chk("t5_held_owner", 32'(lock_owner), 2);
    chk("t5_src0_wait", 32'(src_q[0].size()), 2);
    chk("t5_no_evt", 32'(tevt_cnt), 0);
    chk("t5_sb_empty", 32'(exp_q.size()), 0);
    send(2, "\n");
    expect_line(2, "\n");
    expect_line(0, "z\n");
    drain(40, 0);
    chk("t5_no_evt_end", 32'(tevt_cnt), 0);
`endif

    // reset mid-line with a held byte
    reset_dut();
    out_ready = 1'b0;
    send(1, "pqr\n");
    repeat (3) step();
    chk("t6_held_valid", 32'(out_valid), 1);
    chk("t6_held_data", 32'(out_data), 32'h70);
    chk("t6_held_src", 32'(out_src), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_data", 32'(out_data), 0);
    chk("t6_rst_src", 32'(out_src), 0);
    chk("t6_rst_locked", 32'(locked), 0);
    chk("t6_rst_owner", 32'(lock_owner), 0);
    chk("t6_rst_ready", 32'(req_ready), 0);
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    seen_out = 0;
    send(2, "m\n");
    send(0, "n\n");
    expect_line(0, "n\n");
    expect_line(2, "m\n");
    drain(40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/uart_line_arbiter.md
# uart_line_arbiter

Line-granular arbiter that shares one simulation UART byte sink between several byte-stream sources, e.g. kernel, log and app. A source is granted the sink for a whole line, so characters from different streams never interleave within a printed line. The output is one registered byte stream tagged with its source index, which feeds a single line printer or log sink downstream.

## Interface
- `NREQ`, 3: number of requesting byte streams (2..8)
- `TIMEOUT`, 1024: idle cycles before a held lock is forcibly released (used only with the timeout feature)
- `clk`  in  1: single clock
- `resetn`  in  1: reset; one clock, asynchronous, active-low
- `req_data`  in  NREQ×8: per-source byte
- `req_valid`  in  NREQ: per-source byte valid
- `req_ready`  out  NREQ: per-source accept; a byte transfers when valid & ready
- `out_data`  out  8: granted byte
- `out_valid`  out  1: output register holds a byte
- `out_ready`  in  1: sink accepts
- `out_src`  out  clog2(NREQ): source index of `out_data`
- `out_eol`  out  1: `out_data` is 0x0a or 0x0d
- `lock_owner`  out  clog2(NREQ): current owner, valid while `locked`
- `locked`  out  1: FSM is in LOCKED
- `timeout_evt`  out  1: one-cycle pulse when a lock is released by timeout

## Operation
- FSM states: IDLE, LOCKED.
- IDLE behaviour:
  - No `req_ready` is asserted.
  - If any `req_valid` is high, grant the first valid source scanning round-robin from `last+1` (mod NREQ).
  - Load `lock_owner` and go to LOCKED. The arbitration cycle does not transfer a byte.
- LOCKED behaviour:
  - `req_ready[owner] = ~out_valid | out_ready`. All other `req_ready` are 0.
  - On a transfer, the byte, owner and EOL flag load the output register.
  - If the transferred byte is 0x0a or 0x0d: set `last` = owner and go to IDLE in the same edge.
- Output register:
  - Loads on transfer. Clears `out_valid` on `out_ready` with no new load.
  - Simultaneous drain and load keeps `out_valid` = 1 with the new byte.
- Requesters not granted are stalled. Their bytes must be held stable (valid/ready rule: no withdrawal).
- Owner drops `req_valid` mid-line: the lock is held. The FSM does not return to IDLE on gaps.
- CR+LF pairs are two separate lines. The second terminator may be granted to another source first; this is accepted.
- Reset values: state IDLE, `out_valid` 0, `out_data` 0, `out_src` 0, `out_eol` 0, `lock_owner` 0, `locked` 0, `timeout_evt` 0, `last` = NREQ-1 (so source 0 has priority after reset), idle counter 0.
- Reset mid-line discards the partial grant and any held output byte.

## Timing
- Latency, request to first byte on the output:
  - Source asserts `req_valid` in IDLE at cycle N.
  - Grant at edge N+1.
  - Transfer during N+1.
  - `out_valid` at N+2.
- Steady state: one byte per cycle while `out_ready` = 1.
- Line end to next grant: the terminator transfers at cycle M, the FSM is IDLE at M+1, and the next source transfers at M+2. That is one bubble cycle per line.
- `out_ready` low: the output holds, `req_ready` falls combinationally in the same cycle, and no byte is lost.
- All outputs are registered except `req_ready`, which is combinational from the state, `out_valid` and `out_ready`.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - In LOCKED, a clog2(TIMEOUT+1) counter increments on each cycle with no transfer and clears on each transfer.
  - At count TIMEOUT-1 with no transfer: go to IDLE, set `last` = owner, pulse `timeout_evt`.
  - A transfer in the same cycle as the threshold wins: the lock is kept and the counter clears.
- Not defined: no counter, `timeout_evt` is tied 0, and a lock is released only by a terminator byte.

## Structure
- Package `uart_arb_pkg`:
  - `arb_state_e` {IDLE, LOCKED}
  - `CHAR_LF` = 8'h0a, `CHAR_CR` = 8'h0d
  - function `is_eol(byte)`
- Sub-module `rr_pick`: combinational round-robin first-valid finder; inputs `req` vector and `last` pointer; outputs `grant_idx` and `any`.
- Everything else lives in `uart_line_arbiter`.

## Test plan
- Single source 0 sends "hi\n" with `out_ready` = 1 → `out_valid` at cycle N+2; outputs 0x68, 0x69, 0x0a on consecutive cycles with `out_src` = 0; `out_eol` only on 0x0a; `locked` falls the cycle after.
- Sources 0 and 1 both send "ab\n" starting in the same cycle → the full line from src 0, then one idle bubble, then the full line from src 1; bytes never interleave.
- Three sources continuously request one-char lines "x\n" → grant order 0, 1, 2, 0, 1, 2 (round-robin fairness).
- Source 1 sends "abc\n" while `out_ready` toggles 1,0,0,1,… → all four bytes are delivered in order with none duplicated or dropped; `req_ready[1]` is low whenever `out_valid` & ~`out_ready`.
- With `UART_ARB_TIMEOUT_EN` and TIMEOUT = 8, source 2 sends "ab" and then stops while source 0 waits → `timeout_evt` pulses after 8 idle cycles and source 0 is granted next. Without the macro, source 0 stays stalled indefinitely.
- `resetn` is asserted mid-line with a byte held in the output register → all outputs take their reset values immediately; after release, a pending request from source 2 is granted only after source 0, if source 0 is also requesting.
